settings_bank: RTL and testbench

- Parametrised, double-buffered successor of the Doppler settings register file.
- Host writes go into a shadow bank. The whole bank is copied atomically into an active bank on a commit request, aligned to the next transmit-frame boundary from the sequencer.
- State-machine timing values and settings never change mid-frame.
- Active bank drives the sequencer start values and the decoded control fields (enable, RX/TX, gate length, frequency).

---
 rtl/settings_bank.sv | 130 +++++++++++++
 tb/tb_settings_bank.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/settings_bank.sv
// Double-buffered settings register file: host writes land in a shadow bank,
// and a commit copies the whole bank into the active bank at a frame boundary.
module settings_bank #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int CTRL_INDEX = 4,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALUES = '0
) (
  input  logic                           MEM_CLK,
  input  logic                           MEM_RST,
  input  logic [ADDR_WIDTH-1:0]          MEM_ADDR,
  input  logic [DATA_WIDTH-1:0]          MEM_WDATA,
  input  logic                           MEM_WE,
  input  logic                           MEM_RE,
  input  logic                           MEM_RSEL,
  output logic [DATA_WIDTH-1:0]          MEM_RDATA,
  output logic                           MEM_RVALID,
  output logic                           MEM_ERR,
  input  logic                           COMMIT_REQ,
  input  logic                           FRAME_SYNC,
  output logic                           COMMIT_PENDING,
  output logic                           COMMIT_DONE,
  output logic                           DIRTY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] ACTIVE_REGS,
  output logic                           ENABLE,
  output logic                           RX_ON,
  output logic [1:0]                     TX_ON,
  output logic [7:0]                     GATE_LENGTH,
  output logic [1:0]                     FREQUENCY,
  output logic [1:0]                     DBG_STATE
);

  // Handshakes: MEM_RE is a single-cycle request with no back-pressure; the
  // cycle after it MEM_RVALID pulses with MEM_RDATA (0 when out of range) and
  // MEM_ERR flags a bad address. COMMIT_REQ is accepted only in IDLE, then
  // COMMIT_PENDING holds until the copy and COMMIT_DONE pulses right after it.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_COPY    = 2'd2;

  logic [DATA_WIDTH-1:0] shadow [NUM_REGS];
  logic [DATA_WIDTH-1:0] active [NUM_REGS];
  logic [1:0]            state;
  logic [31:0]           addr_ext;
  logic                  in_range;
  logic                  wr_en;
  logic                  copy_now;
  logic [DATA_WIDTH-1:0] shadow_rd;
  logic [DATA_WIDTH-1:0] active_rd;

  assign addr_ext = 32'(MEM_ADDR);
  assign in_range = addr_ext < 32'(NUM_REGS);
  assign wr_en    = MEM_WE && in_range;
  // With no frame running there is no boundary to wait for.
  assign copy_now = (state == ST_PENDING) && (FRAME_SYNC || !ENABLE);

  always_comb begin
    shadow_rd = '0;
    active_rd = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (MEM_ADDR == ADDR_WIDTH'(i)) begin
        shadow_rd = shadow[i];
        active_rd = active[i];
      end
    end
  end

  always_ff @(posedge MEM_CLK) begin
    if (MEM_RST) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow[i] <= RESET_VALUES[i*DATA_WIDTH +: DATA_WIDTH];
        active[i] <= RESET_VALUES[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end else begin
      // Non-blocking copy gives active the pre-write shadow on a coincident write.
      for (int i = 0; i < NUM_REGS; i++) begin
        if (copy_now) active[i] <= shadow[i];
        if (wr_en && (MEM_ADDR == ADDR_WIDTH'(i))) shadow[i] <= MEM_WDATA;
      end
    end
  end

  always_ff @(posedge MEM_CLK) begin
    if (MEM_RST) begin
      MEM_RDATA  <= '0;
      MEM_RVALID <= 1'b0;
      MEM_ERR    <= 1'b0;
    end else begin
      MEM_RVALID <= MEM_RE;
      MEM_ERR    <= (MEM_RE || MEM_WE) && !in_range;
      if (MEM_RE) begin
        if (!in_range)     MEM_RDATA <= '0;
        else if (MEM_RSEL) MEM_RDATA <= active_rd;
        else               MEM_RDATA <= shadow_rd;
      end
    end
  end

  always_ff @(posedge MEM_CLK) begin
    if (MEM_RST) begin
      state <= ST_IDLE;
      DIRTY <= 1'b0;
    end else begin
      if (copy_now)   DIRTY <= wr_en;
      else if (wr_en) DIRTY <= 1'b1;
      case (state)
        ST_IDLE:    if (COMMIT_REQ) state <= ST_PENDING;
        ST_PENDING: if (copy_now) state <= ST_COPY;
        ST_COPY:    state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  assign COMMIT_PENDING = (state == ST_PENDING);
  assign COMMIT_DONE    = (state == ST_COPY);
  assign DBG_STATE      = state;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign ACTIVE_REGS[g*DATA_WIDTH +: DATA_WIDTH] = active[g];
  end

  assign ENABLE      = active[CTRL_INDEX][2];
  assign RX_ON       = ~active[CTRL_INDEX][1];
  assign TX_ON       = {2{active[CTRL_INDEX][0]}};
  assign GATE_LENGTH = active[CTRL_INDEX][13:6];
  assign FREQUENCY   = active[CTRL_INDEX][15:14];

endmodule

// File: tb/tb_settings_bank.sv
// Directed bench for settings_bank: reset image, reads, commits, copy-edge
// writes, out-of-range accesses and reset while a commit is pending.
module tb_settings_bank;

  localparam int DW = 16;
  localparam int NR = 5;
  localparam int AW = 3;
  localparam logic [NR*DW-1:0] RST_IMG_P =
    {16'h9F07, 16'h4444, 16'h3333, 16'h2222, 16'h1111};

  logic           MEM_CLK = 1'b0;
  logic           MEM_RST = 1'b1;
  logic [AW-1:0]  MEM_ADDR = '0;
  logic [DW-1:0]  MEM_WDATA = '0;
  logic           MEM_WE = 1'b0;
  logic           MEM_RE = 1'b0;
  logic           MEM_RSEL = 1'b0;
  logic [DW-1:0]  MEM_RDATA;
  logic           MEM_RVALID;
  logic           MEM_ERR;
  logic           COMMIT_REQ = 1'b0;
  logic           FRAME_SYNC = 1'b0;
  logic           COMMIT_PENDING;
  logic           COMMIT_DONE;
  logic           DIRTY;
  logic [NR*DW-1:0] ACTIVE_REGS;
  logic           ENABLE;
  logic           RX_ON;
  logic [1:0]     TX_ON;
  logic [7:0]     GATE_LENGTH;
  logic [1:0]     FREQUENCY;
  logic [1:0]     DBG_STATE;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt;
  logic [DW-1:0] exp_q[$];
  logic [NR*DW-1:0] rst_img;

  settings_bank #(
    .DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW), .CTRL_INDEX(4),
    .RESET_VALUES(RST_IMG_P)
  ) dut (
    .MEM_CLK(MEM_CLK), .MEM_RST(MEM_RST), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_WE(MEM_WE), .MEM_RE(MEM_RE),
    .MEM_RSEL(MEM_RSEL), .MEM_RDATA(MEM_RDATA), .MEM_RVALID(MEM_RVALID),
    .MEM_ERR(MEM_ERR), .COMMIT_REQ(COMMIT_REQ), .FRAME_SYNC(FRAME_SYNC),
    .COMMIT_PENDING(COMMIT_PENDING), .COMMIT_DONE(COMMIT_DONE),
    .DIRTY(DIRTY), .ACTIVE_REGS(ACTIVE_REGS), .ENABLE(ENABLE),
    .RX_ON(RX_ON), .TX_ON(TX_ON), .GATE_LENGTH(GATE_LENGTH),
    .FREQUENCY(FREQUENCY), .DBG_STATE(DBG_STATE)
  );

  // Clock / reset
  always #5 MEM_CLK = ~MEM_CLK;

  task automatic tick();
    @(posedge MEM_CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] act(input int i);
    return ACTIVE_REGS[i*DW +: DW];
  endfunction

  // Drivers
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    MEM_ADDR = a; MEM_WDATA = d; MEM_WE = 1'b1;
    tick();
    MEM_WE = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic rsel, input logic [AW-1:0] a,
                          input logic [DW-1:0] exp);
    logic [DW-1:0] e;
    exp_q.push_back(exp);
    MEM_ADDR = a; MEM_RSEL = rsel; MEM_RE = 1'b1;
    tick();
    MEM_RE = 1'b0;
    e = exp_q.pop_front();
    check({tag, "_rvalid"}, 32'(MEM_RVALID), 32'd1);
    check(tag, 32'(MEM_RDATA), 32'(e));
  endtask

  initial begin
    rst_img = RST_IMG_P;
    tick(); tick();
    MEM_RST = 1'b0;

    // Reset state and decoded reset ctrl word
    check("rst_enable", 32'(ENABLE), 32'd1);
    check("rst_rx_on", 32'(RX_ON), 32'd0);
    check("rst_tx_on", 32'(TX_ON), 32'd3);
    check("rst_gate", 32'(GATE_LENGTH), 32'h7C);
    check("rst_freq", 32'(FREQUENCY), 32'd2);
    check("rst_dirty", 32'(DIRTY), 32'd0);
    check("rst_pending", 32'(COMMIT_PENDING), 32'd0);
    check("rst_done", 32'(COMMIT_DONE), 32'd0);
    check("rst_rvalid", 32'(MEM_RVALID), 32'd0);
    check("rst_rdata", 32'(MEM_RDATA), 32'd0);
    check("rst_state", 32'(DBG_STATE), 32'd0);
    rd_check("rst_rd_ctrl", 1'b1, 3'd4, 16'h9F07);
    tick();
    check("rvalid_pulse", 32'(MEM_RVALID), 32'd0);

    // Commit aligned to FRAME_SYNC while ENABLE=1, plus a write during PENDING
    wr(3'd0, 16'h1234);
    check("wr0_dirty", 32'(DIRTY), 32'd1);
    check("wr0_act_old", 32'(act(0)), 32'h1111);
    rd_check("wr0_rd_shadow", 1'b0, 3'd0, 16'h1234);
    COMMIT_REQ = 1'b1; tick(); COMMIT_REQ = 1'b0;
    check("req_pending", 32'(COMMIT_PENDING), 32'd1);
    check("req_state", 32'(DBG_STATE), 32'd1);
    for (int k = 0; k < 4; k++) begin
      if (k == 1) wr(3'd3, 16'hBEEF);
      else tick();
      check("wait_pending", 32'(COMMIT_PENDING), 32'd1);
      check("wait_act0", 32'(act(0)), 32'h1111);
      check("wait_done", 32'(COMMIT_DONE), 32'd0);
    end
    FRAME_SYNC = 1'b1; tick(); FRAME_SYNC = 1'b0;
    check("fs_done", 32'(COMMIT_DONE), 32'd1);
    check("fs_state", 32'(DBG_STATE), 32'd2);
    check("fs_act0", 32'(act(0)), 32'h1234);
    check("fs_act3", 32'(act(3)), 32'hBEEF);
    check("fs_dirty", 32'(DIRTY), 32'd0);
    check("fs_pending", 32'(COMMIT_PENDING), 32'd0);
    tick();
    check("fs_done_pulse", 32'(COMMIT_DONE), 32'd0);
    check("fs_idle", 32'(DBG_STATE), 32'd0);
    FRAME_SYNC = 1'b1; tick(); FRAME_SYNC = 1'b0;
    check("idle_fs_pending", 32'(COMMIT_PENDING), 32'd0);
    check("idle_fs_done", 32'(COMMIT_DONE), 32'd0);

    // FRAME_SYNC coincident with REQ does not trigger; ctrl=0 decodes
    wr(3'd4, 16'h0000);
    COMMIT_REQ = 1'b1; FRAME_SYNC = 1'b1; tick();
    COMMIT_REQ = 1'b0; FRAME_SYNC = 1'b0;
    check("coinc_pending", 32'(COMMIT_PENDING), 32'd1);
    tick();
    check("coinc_still_pend", 32'(COMMIT_PENDING), 32'd1);
    check("coinc_no_done", 32'(COMMIT_DONE), 32'd0);
    FRAME_SYNC = 1'b1; tick(); FRAME_SYNC = 1'b0;
    check("ctrl0_done", 32'(COMMIT_DONE), 32'd1);
    check("ctrl0_enable", 32'(ENABLE), 32'd0);
    check("ctrl0_tx_on", 32'(TX_ON), 32'd0);
    check("ctrl0_rx_on", 32'(RX_ON), 32'd1);
    check("ctrl0_gate", 32'(GATE_LENGTH), 32'd0);
    check("ctrl0_freq", 32'(FREQUENCY), 32'd0);
    tick();

    // ENABLE=0: DONE two cycles after REQ
    wr(3'd1, 16'h00AA);
    COMMIT_REQ = 1'b1; tick(); COMMIT_REQ = 1'b0;
    check("fast_pending", 32'(COMMIT_PENDING), 32'd1);
    check("fast_no_done", 32'(COMMIT_DONE), 32'd0);
    tick();
    check("fast_done", 32'(COMMIT_DONE), 32'd1);
    check("fast_act1", 32'(act(1)), 32'h00AA);
    check("fast_dirty", 32'(DIRTY), 32'd0);
    tick();

    // Write on the copy edge
    COMMIT_REQ = 1'b1; tick(); COMMIT_REQ = 1'b0;
    wr(3'd2, 16'h5555);
    check("cwr_done", 32'(COMMIT_DONE), 32'd1);
    check("cwr_act2_old", 32'(act(2)), 32'h3333);
    check("cwr_dirty", 32'(DIRTY), 32'd1);
    rd_check("cwr_shadow2", 1'b0, 3'd2, 16'h5555);

    // Out-of-range write+read at address 7, read at address 5
    MEM_ADDR = 3'd7; MEM_WDATA = 16'hFFFF; MEM_RSEL = 1'b0;
    MEM_WE = 1'b1; MEM_RE = 1'b1;
    tick();
    MEM_WE = 1'b0; MEM_RE = 1'b0;
    check("oor_rvalid", 32'(MEM_RVALID), 32'd1);
    check("oor_rdata", 32'(MEM_RDATA), 32'd0);
    check("oor_err", 32'(MEM_ERR), 32'd1);
    check("oor_dirty", 32'(DIRTY), 32'd1);
    tick();
    check("oor_err_pulse", 32'(MEM_ERR), 32'd0);
    rd_check("oor_sh0", 1'b0, 3'd0, 16'h1234);
    check("inr_err", 32'(MEM_ERR), 32'd0);
    rd_check("oor_sh1", 1'b0, 3'd1, 16'h00AA);
    rd_check("oor_sh2", 1'b0, 3'd2, 16'h5555);
    rd_check("oor_sh3", 1'b0, 3'd3, 16'hBEEF);
    rd_check("oor_sh4", 1'b0, 3'd4, 16'h0000);
    rd_check("oor_act2", 1'b1, 3'd2, 16'h3333);
    rd_check("oor_addr5", 1'b1, 3'd5, 16'h0000);
    check("oor_addr5_err", 32'(MEM_ERR), 32'd1);

    // REQ held across PENDING and COPY yields one DONE
    done_cnt = 0;
    COMMIT_REQ = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (COMMIT_DONE) done_cnt++;
    end
    COMMIT_REQ = 1'b0;
    check("req_in_copy_pend", 32'(COMMIT_PENDING), 32'd0);
    tick();
    if (COMMIT_DONE) done_cnt++;
    check("dup_req_pending", 32'(COMMIT_PENDING), 32'd0);
    check("dup_req_done_cnt", 32'(done_cnt), 32'd1);
    check("dup_act2", 32'(act(2)), 32'h5555);
    check("dup_dirty", 32'(DIRTY), 32'd0);

    // Reset while PENDING discards the request
    wr(3'd4, 16'h0004);
    COMMIT_REQ = 1'b1; tick(); COMMIT_REQ = 1'b0;
    tick();
    check("en_commit_done", 32'(COMMIT_DONE), 32'd1);
    check("en_enable", 32'(ENABLE), 32'd1);
    tick();
    wr(3'd0, 16'hCAFE);
    COMMIT_REQ = 1'b1; tick(); COMMIT_REQ = 1'b0;
    tick();
    check("mid_pending", 32'(COMMIT_PENDING), 32'd1);
    MEM_RST = 1'b1; tick(); MEM_RST = 1'b0;
    check("mrst_pending", 32'(COMMIT_PENDING), 32'd0);
    check("mrst_done", 32'(COMMIT_DONE), 32'd0);
    check("mrst_dirty", 32'(DIRTY), 32'd0);
    check("mrst_rdata", 32'(MEM_RDATA), 32'd0);
    tick();
    check("mrst_no_done", 32'(COMMIT_DONE), 32'd0);
    for (int i = 0; i < NR; i++)
      check($sformatf("mrst_act%0d", i), 32'(act(i)), 32'(rst_img[i*DW +: DW]));
    rd_check("mrst_sh0", 1'b0, 3'd0, 16'h1111);
    check("mrst_gate", 32'(GATE_LENGTH), 32'h7C);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #50000;
    n_errors++;
    $display("FAIL timeout: got no finish expected finish");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
